// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_e;

    // One radix-4 digit per two bits of B, plus one for the extension bit.
    function automatic int unsigned booth_iter(input int unsigned wb);
        return (wb + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: a 3-bit window of B' selects a digit, which scales A'.
module booth_r4_recode
    import seq_mult_pkg::*;
#(
    parameter int unsigned WA = 8
) (
    input  logic [2:0]    bits,
    input  logic [WA:0]   a_ext,
    output booth_digit_e  digit,
    output logic [WA+1:0] pp
);

    // A' spans -2^(WA-1)..2^WA-1, so +-2*A' always fits in WA+2 bits.
    function automatic logic [WA+1:0] scale(input booth_digit_e d, input logic [WA:0] a);
        logic [WA+1:0] a1;
        logic [WA+1:0] a2;
        a1 = {a[WA], a};
        a2 = {a, 1'b0};
        case (d)
            P1:      return a1;
            P2:      return a2;
            M1:      return -a1;
            M2:      return -a2;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        digit = ZERO;
        case (bits)
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
    end

    assign pp = scale(digit, a_ext);

endmodule

// File: rtl/seq_booth_mult.sv
// Iterative radix-4 Booth multiplier with valid/ready on both sides and
// per-operation operand signedness.
module seq_booth_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WA = 8,
    parameter int unsigned WB = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WA-1:0] a,
    input  logic [WB-1:0] b,
    input  logic          a_signed,
    input  logic          b_signed,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WA+WB-1:0] product,
    output logic          busy
);

    localparam int unsigned ITER = booth_iter(WB);
    localparam int unsigned BW   = 2 * ITER;
    localparam int unsigned PW   = WA + WB;
    localparam int unsigned ACCW = PW + 2;
    localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_e state;
    state_e state_nx;

    logic [WA:0]     areg;
    logic [BW-1:0]   breg;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_nx;
    logic [CW-1:0]   cnt;

    logic [WB:0]     b_ext;
    logic [BW:0]     b_win;
    logic [2:0]      triple;
    booth_digit_e    digit;
    logic [WA+1:0]   pp;
    logic [ACCW-1:0] addend;
    logic            accept;
    logic            step;

    assign b_ext  = {b_signed & b[WB-1], b};
    // Appending the implicit bit -1 lets every window be a plain 3-bit slice.
    assign b_win  = {breg, 1'b0};
    assign triple = 3'(b_win >> {cnt, 1'b0});

    booth_r4_recode #(
        .WA (WA)
    ) u_recode (
        .bits  (triple),
        .a_ext (areg),
        .digit (digit),
        .pp    (pp)
    );

    assign addend = ACCW'($signed(pp)) << {cnt, 1'b0};
    assign acc_nx = (digit == ZERO) ? acc : acc + addend;

    assign accept = (state == IDLE) && in_valid && !flush;
    assign step   = (state == CALC) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CALC;
            end
            CALC: begin
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg    <= '0;
            breg    <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            areg <= {a_signed & a[WA-1], a};
            breg <= BW'($signed(b_ext));
            acc  <= '0;
            cnt  <= '0;
        end else if (step) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) product <= acc_nx[PW-1:0];
        end
    end

endmodule

// File: doc/seq_booth_mult.md
Name: seq_booth_mult

Overview:
- Parametrised, iterative radix-4 Booth multiplier. It is the sequential successor to the team's flat gate-level array multipliers.
- Computes the product of A[WA] and B[WB] in ceil((WB+1)/2) clocks. Signedness of each operand is selected per operation.
- Valid/ready handshakes on both input and output. Sits between operand issue logic and a result consumer that may stall.

Parameters:
WA, 8, width of operand A (>=2)
WB, 8, width of operand B (>=2)
ITER, ceil((WB+1)/2), Booth iteration count (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept operands
a  in  WA  operand A
b  in  WB  operand B
a_signed  in  1  1 = A is two's complement, 0 = unsigned
b_signed  in  1  1 = B is two's complement, 0 = unsigned
flush  in  1  synchronous abort of any operation in flight
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  WA+WB  low WA+WB bits of the exact product
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, product=0, busy=0, all internal registers 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 on an edge captures the operands:
    - A' = {a_signed?a[WA-1]:0, a} (WA+1 bits, signed)
    - B' = {b_signed?b[WB-1]:0, b}, sign-extended to 2*ITER bits
  - Captures clear the accumulator and the counter, then go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, recode one Booth digit from B' bits {2i+1, 2i, 2i-1} (bit -1 = 0) to one of {-2,-1,0,+1,+2}.
  - Add digit*A' << 2i into a signed accumulator of WA+WB+2 bits.
  - Counter 0..ITER-1. After digit ITER-1 is added, go to DONE.
- DONE:
  - out_valid=1. product = accumulator[WA+WB-1:0], registered and held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE and set out_valid=0.
  - in_ready=0 in DONE; there is no overlap of issue and drain.
- Latency: out_valid rises exactly ITER clock edges after the accepting edge. Throughput is one product per ITER+2 cycles with out_ready held at 1.
- Result is exact modulo 2^(WA+WB) for all four signedness combinations.
  - unsigned x unsigned and signed x signed: the full product fits in WA+WB bits.
  - Mixed: the result is the two's-complement truncation.
- flush=1 on any edge: next state IDLE, out_valid=0, product is unchanged.
  - flush takes priority over the in_valid capture and the out_ready pop in the same cycle.
- in_valid while in_ready=0: ignored, no capture. The source must hold its request.
- a, b and the signed flags are sampled only on the accepting edge. Later changes have no effect.
- Reset asserted mid-CALC or mid-DONE: immediately forces the reset values. The operation is lost and no partial product is ever presented.
- Edge widths:
  - WB odd: B' is padded with the sign bit to an even width.
  - WA=2 and WB=2: ITER=2.

Decomposition:
- Package seq_mult_pkg:
  - state enum {IDLE, CALC, DONE}
  - Booth digit enum {ZERO, P1, P2, M1, M2}
  - function booth_iter(WB) returning ceil((WB+1)/2)
- One sub-module: booth_r4_recode. It is combinational: 3 bits in, digit out, plus a helper that forms digit*A' (WA+2 bits).
- The FSM, counter and accumulator live in the top module.

Test Plan:
- Unsigned 255x255, WA=WB=8, out_ready=1:
  - product=16'hFE01.
  - out_valid rises 5 edges after accept.
  - in_ready returns to 1 one cycle after the pop.
- Signed -128x-128 (8'h80, 8'h80): product=16'h4000. Signed -128x127: product=16'hC080.
- Mixed a_signed=1 a=8'hFF, b_signed=0 b=8'hFF (-1x255): product=16'hFF01. Swapped flags give the same result.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - product is stable and out_valid=1 throughout.
  - in_valid pulses during the stall are ignored.
  - Pop on out_ready=1, then a new request 3x5 gives 16'h000F.
- flush on the 2nd CALC cycle of 100x100:
  - next cycle state=IDLE, out_valid stays 0.
  - A following 7x6 gives 16'h002A with nominal latency.
- Async rst asserted mid-CALC between clock edges:
  - outputs reach reset values without a clock edge.
  - After release, 1x1 gives 16'h0001.
  - Random sweep of 10k operands, all signedness modes, WA=5/WB=7 against a reference model.
